// File: rtl/compound_acc_pkg.sv
// Shared opcode/state encodings for the compound accumulator.
// Imported by compound_acc_unit and compound_acc_mul.
package compound_acc_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_LOAD = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_SSHL = 4'd9,
    OP_SSHR = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/compound_acc_mul.sv
// Iterative WIDTH-cycle shift-add multiplier, low WIDTH bits kept.
// Ports: clk, rst_n, start_i, a_i, b_i -> busy_o, done_o (1-cycle pulse), p_o.
module compound_acc_mul #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        a_q    <= a_i;
        b_q    <= b_i;
        p_q    <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (b_q[0]) p_q <= p_q + a_q;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: rtl/compound_acc_unit.sv
// Accumulator stage applying "c op= b" per accepted request, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready/in_op/in_b, out_valid/out_ready/out_c.
// Option: ACC_SIGNED_SSHR_EN makes OP_SSHR an arithmetic (sign-filling) shift.
module compound_acc_unit #(
  parameter int WIDTH = 4,
  parameter int OPW   = compound_acc_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c
);

  import compound_acc_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             pend_q, pend_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] alu;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_p;
  op_e              op;

  assign op = op_e'(op_q);

  compound_acc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (acc_q),
    .b_i     (in_b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // Shifts by b >= WIDTH fall out naturally as 0 (or sign fill).
  always_comb begin
    alu = acc_q;
    unique case (op)
      OP_LOAD: alu = b_q;
      OP_ADD:  alu = acc_q + b_q;
      OP_SUB:  alu = acc_q - b_q;
      OP_AND:  alu = acc_q & b_q;
      OP_OR:   alu = acc_q | b_q;
      OP_XOR:  alu = acc_q ^ b_q;
      OP_SHL,
      OP_SSHL: alu = acc_q << b_q;
      OP_SHR:  alu = acc_q >> b_q;
`ifdef ACC_SIGNED_SSHR_EN
      OP_SSHR: alu = $unsigned($signed(acc_q) >>> b_q);
`else
      OP_SSHR: alu = acc_q >> b_q;
`endif
      default: alu = acc_q;
    endcase
  end

  // DONE has three phases: write acc (pend), raise valid, await ready.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    b_d       = b_q;
    pend_d    = pend_q;
    vld_d     = vld_q;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d = in_op;
          b_d  = in_b;
          if (op_e'(in_op) == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            pend_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          acc_d   = mul_p;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pend_q) begin
          acc_d  = alu;
          pend_d = 1'b0;
        end else if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      b_q     <= b_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE) && !mul_busy;
  assign out_valid = vld_q;
  assign out_c     = acc_q;

endmodule

// File: tb/tb_compound_acc_unit.sv
// Self-checking bench for compound_acc_unit against an arithmetic model.
// Honours ACC_SIGNED_SSHR_EN the same way as the design.
module tb_compound_acc_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_op = '0;
  logic [3:0] in_b = '0;
  logic       in_ready, out_valid;
  logic [3:0] out_c;

  int errors = 0;
  int checks = 0;
  int acc_m = 0;

  always #5 clk = ~clk;

  compound_acc_unit #(.WIDTH(4), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
  );

  function automatic int model(int op, int a, int b);
    int s;
    case (op)
      0: return b;
      1: return (a + b) % 16;
      2: return (a - b + 16) % 16;
      3: return (a * b) % 16;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7, 9: return (b >= 4) ? 0 : ((a << b) % 16);
      8: return (b >= 4) ? 0 : (a >> b);
      10: begin
`ifdef ACC_SIGNED_SSHR_EN
        s = (a >= 8) ? a - 16 : a;
        return (s >>> b) & 15;
`else
        s = 0;
        return (b >= 4) ? s : (a >> b);
`endif
      end
      default: return a;
    endcase
  endfunction

  // Drives one request and acknowledges its result; reports value,
  // cycles from accept edge to out_valid, and whether in_ready rose meanwhile.
  task automatic send(input int op, input int b, output logic [3:0] c,
                      output int lat, output bit rdy_seen);
    int t;
    t = 0;
    rdy_seen = 1'b0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_op = 4'(op);
    in_b = 4'(b);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    c = out_c;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_c !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold got rdy=%b vld=%b c=%0d exp 0 0 0", in_ready, out_valid, out_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_c !== 4'd0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b c=%0d exp 1 0 0", in_ready, out_valid, out_c);
    end
    acc_m = 0;
  endtask

  task automatic test_add_wrap;
    logic [3:0] c;
    int lat;
    bit rs;
    int ops[3] = '{0, 1, 1};
    int bs[3] = '{5, 3, 9};
    int exp[3] = '{5, 8, 1};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], bs[i], c, lat, rs);
      checks++;
      if (c !== 4'(exp[i]) || lat != 2) begin
        errors++;
        $display("FAIL add_wrap[%0d] got c=%0d lat=%0d exp c=%0d lat=2", i, c, lat, exp[i]);
      end
    end
    acc_m = 1;
  endtask

  task automatic test_logic;
    logic [3:0] c;
    int lat;
    bit rs;
    int ops[5] = '{0, 2, 0, 4, 6};
    int bs[5] = '{2, 5, 13, 10, 15};
    int exp[5] = '{2, 13, 13, 8, 7};
    for (int i = 0; i < 5; i++) begin
      send(ops[i], bs[i], c, lat, rs);
      checks++;
      if (c !== 4'(exp[i]) || lat != 2) begin
        errors++;
        $display("FAIL logic[%0d] got c=%0d lat=%0d exp c=%0d lat=2", i, c, lat, exp[i]);
      end
    end
    acc_m = 7;
  endtask

  task automatic test_mul;
    logic [3:0] c;
    int lat;
    bit rs;
    send(0, 7, c, lat, rs);
    send(3, 3, c, lat, rs);
    checks++;
    if (c !== 4'd5 || lat != 6 || rs) begin
      errors++;
      $display("FAIL mul got c=%0d lat=%0d rdy=%b exp c=5 lat=6 rdy=0", c, lat, rs);
    end
    acc_m = 5;
  endtask

  task automatic test_shift;
    logic [3:0] c;
    int lat;
    bit rs;
    logic [3:0] e1, e2;
`ifdef ACC_SIGNED_SSHR_EN
    e1 = 4'b1100;
    e2 = 4'b1111;
`else
    e1 = 4'b0100;
    e2 = 4'b0000;
`endif
    send(0, 8, c, lat, rs);
    send(10, 1, c, lat, rs);
    checks++;
    if (c !== e1) begin
      errors++;
      $display("FAIL sshr1 got %b exp %b", c, e1);
    end
    send(0, 8, c, lat, rs);
    send(10, 7, c, lat, rs);
    checks++;
    if (c !== e2) begin
      errors++;
      $display("FAIL sshr_big got %b exp %b", c, e2);
    end
    send(0, 3, c, lat, rs);
    send(7, 5, c, lat, rs);
    checks++;
    if (c !== 4'd0) begin
      errors++;
      $display("FAIL shl_big got %b exp 0000", c);
    end
    send(0, 9, c, lat, rs);
    send(12, 4, c, lat, rs);
    checks++;
    if (c !== 4'd9 || lat != 2) begin
      errors++;
      $display("FAIL illegal_op got c=%0d lat=%0d exp c=9 lat=2", c, lat);
    end
    acc_m = 9;
  endtask

  task automatic test_backpressure;
    logic [3:0] c;
    int lat;
    bit rs;
    int t;
    in_op = 4'd1;
    in_b = 4'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_op = 4'd0;
    in_b = 4'd0;
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_c !== 4'd10 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d] got vld=%b c=%0d rdy=%b exp 1 10 0", i, out_valid, out_c, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(5, 0, c, lat, rs);
    checks++;
    if (c !== 4'd10) begin
      errors++;
      $display("FAIL backpressure_after got c=%0d exp 10", c);
    end
    acc_m = 10;
  endtask

  task automatic test_reset_mid_mul;
    logic [3:0] c;
    int lat;
    bit rs;
    send(0, 7, c, lat, rs);
    in_op = 4'd3;
    in_b = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_c !== 4'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got c=%0d rdy=%b vld=%b exp 0 0 0", out_c, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_c !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_after[%0d] got c=%0d rdy=%b vld=%b exp 0 1 0", i, out_c, in_ready, out_valid);
      end
    end
    acc_m = 0;
    send(1, 1, c, lat, rs);
    checks++;
    if (c !== 4'd1) begin
      errors++;
      $display("FAIL rst_then_add got c=%0d exp 1", c);
    end
    acc_m = 1;
  endtask

  task automatic test_random;
    logic [3:0] c;
    int lat, op, b, exp, elat;
    bit rs;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      exp = model(op, acc_m, b);
      elat = (op == 3) ? 6 : 2;
      send(op, b, c, lat, rs);
      checks++;
      if (c !== 4'(exp) || lat != elat || rs) begin
        errors++;
        $display("FAIL random[%0d] op=%0d b=%0d got c=%0d lat=%0d rdy=%b exp c=%0d lat=%0d rdy=0",
                 i, op, b, c, lat, rs, exp, elat);
      end
      acc_m = exp;
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_logic();
    test_mul();
    test_shift();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compound_acc_unit.md
Name: compound_acc_unit

Overview:
Sequential accumulator stage downstream of the 4-bit compound-assignment datapath (add/sub/mul/and/or/xor/shifts). It holds a running register c and applies one "c op= b" per accepted request, then presents the result.
- Upstream and downstream use valid/ready handshakes.
- All ops except multiply complete in one cycle. Multiply is iterative shift-add, so the block has a real FSM.

Parameters:
WIDTH, 4, accumulator and operand width in bits
OPW, 4, opcode width in bits

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_op  input  OPW  opcode (encodings in package)
in_b  input  WIDTH  right-hand operand b, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_c  output  WIDTH  accumulator value after the op

Behaviour:
- Reset (rst_n low, asynchronous, any state): acc=0, state=IDLE, out_valid=0, out_c=0, in_ready=0 while rst_n low. Any multiply in flight is discarded.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready the request is accepted; in_op and in_b are latched.
  - IDLE to MUL for OP_MUL. Every other op goes IDLE to DONE.
  - MUL: WIDTH iterations of shift-add on the latched operands; in_ready=0. After the last iteration, go to DONE.
  - DONE: out_valid=1 and out_c=acc. On out_ready, go to IDLE. out_c and out_valid hold stable while out_ready is low.
- Latency, counted from the accept edge N:
  - Non-mul: acc updated at N+1; out_valid high in the cycle after N+1.
  - Mul: acc updated at N+1+WIDTH; out_valid high in the cycle after that.
- Throughput: one request per (latency+1) cycles minimum. There is no overlap of accept and output.
- Arithmetic: all results truncated modulo 2^WIDTH.
  - OP_LOAD: acc=b.
  - OP_ADD: acc+b. OP_SUB: acc-b (wraps). OP_MUL: low WIDTH bits of acc*b.
  - OP_AND, OP_OR, OP_XOR: bitwise acc with b.
  - OP_SHL and OP_SSHL: acc<<b. OP_SHR: logical acc>>b.
  - OP_SSHR: logical acc>>>b on unsigned operands (see optional feature).
  - Shift amount b is unsigned. b>=WIDTH yields 0 (or sign fill, see optional feature).
- Illegal opcodes (11..15) are accepted, leave acc unchanged, and still produce one out_valid beat.
- in_valid while not in IDLE is ignored. The requester must hold in_valid until in_ready.

Optional Feature:
ACC_SIGNED_SSHR_EN
- Defined: OP_SSHR treats acc as two's-complement and fills with acc[WIDTH-1]. b>=WIDTH gives all copies of the sign bit.
- Undefined: OP_SSHR is identical to OP_SHR.
- No other op changes.

Decomposition:
- Package compound_acc_pkg holds:
  - op_e enum: LOAD=0, ADD=1, SUB=2, MUL=3, AND=4, OR=5, XOR=6, SHL=7, SHR=8, SSHL=9, SSHR=10.
  - state_e enum: IDLE, MUL, DONE.
  - OPW constant.
- One sub-module, compound_acc_mul: iterative WIDTH-cycle shift-add multiplier with start/busy/done.
- Single-cycle ops stay inline in a case statement.

Test Plan:
- LOAD b=5, then ADD b=3 -> out_c=8. Then ADD b=9 -> out_c=1 (wrap). Each out_valid arrives 2 cycles after accept.
- LOAD 2, SUB 5 -> out_c=13. AND 4'b1010 with acc 4'b1101 -> 4'b1000. XOR 4'b1111 -> 4'b0111.
- LOAD 7, MUL 3 -> out_c=5 (21 mod 16). out_valid arrives exactly WIDTH+2=6 cycles after accept; in_ready=0 throughout.
- LOAD 4'b1000, SSHR 1 -> 4'b0100 without macro, 4'b1100 with ACC_SIGNED_SSHR_EN. SHL 5 on 4'b0011 -> 0.
- Backpressure: out_ready low 3 cycles after a result -> out_c and out_valid stable, in_ready=0, and a new in_valid is not accepted until the handshake completes.
- rst_n pulsed low during MUL cycle 2 -> outputs clear immediately (asynchronously). After release: acc=0, in_ready=1, no stale out_valid.
